// File: rtl/mem_responder.sv
// Memory-side responder for CPU load/store requests: one request at a time,
// fixed wait states, little-endian byte store with byte/half/word access.
module mem_responder #(
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);
    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wr_q, wr_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] rdata_q, rdata_d;
    logic        resp_err_q, resp_err_d;
    logic        busy_q, busy_d;
    logic        ready_q, ready_d;

    logic [7:0]  mem [2**ADDR_WIDTH];

    logic        accept, commit;
    logic        cur_wr, cur_err;
    logic [1:0]  cur_size;
    logic [31:0] cur_addr, cur_wdata, load_data;
    logic [ADDR_WIDTH-1:0] idx0, idx1, idx2, idx3;

    assign accept = req_valid && (state_q == ST_IDLE);

    // With zero wait states the access commits on the accept edge itself,
    // so the live request fields are used while idle.
    always_comb begin
        if (state_q == ST_IDLE) begin
            cur_wr    = req_write;
            cur_size  = req_size;
            cur_addr  = req_addr;
            cur_wdata = req_wdata;
        end else begin
            cur_wr    = wr_q;
            cur_size  = size_q;
            cur_addr  = addr_q;
            cur_wdata = wdata_q;
        end
        cur_err = (cur_size == 2'b11)
               || (cur_size == 2'b01 && cur_addr[0])
               || (cur_size == 2'b10 && cur_addr[1:0] != 2'b00)
               || (cur_addr[31:ADDR_WIDTH] != '0);
        idx0 = cur_addr[ADDR_WIDTH-1:0];
        idx1 = idx0 + ADDR_WIDTH'(1);
        idx2 = idx0 + ADDR_WIDTH'(2);
        idx3 = idx0 + ADDR_WIDTH'(3);
        case (cur_size)
            2'b00:   load_data = {24'b0, mem[idx0]};
            2'b01:   load_data = {16'b0, mem[idx1], mem[idx0]};
            default: load_data = {mem[idx3], mem[idx2], mem[idx1], mem[idx0]};
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            ST_IDLE: if (accept) begin
                wr_d    = req_write;
                size_d  = req_size;
                addr_d  = req_addr;
                wdata_d = req_wdata;
                if (WAIT_CYCLES > 0) begin
                    state_d = ST_WAIT;
                    cnt_d   = 4'(WAIT_CYCLES - 1);
                end else begin
                    state_d = ST_RESP;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) state_d = ST_RESP;
                else               cnt_d   = cnt_q - 4'd1;
            end
            default: state_d = ST_IDLE;
        endcase

        commit       = (state_d == ST_RESP);
        rdata_d      = rdata_q;
        resp_err_d   = resp_err_q;
        if (commit) begin
            resp_err_d = cur_err;
            rdata_d    = (cur_err || cur_wr) ? 32'd0 : load_data;
        end
        resp_valid_d = (state_d == ST_RESP);
        busy_d       = (state_d != ST_IDLE);
        ready_d      = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            wr_q         <= 1'b0;
            size_q       <= 2'b00;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            resp_valid_q <= 1'b0;
            rdata_q      <= 32'd0;
            resp_err_q   <= 1'b0;
            busy_q       <= 1'b0;
            ready_q      <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wr_q         <= wr_d;
            size_q       <= size_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            resp_valid_q <= resp_valid_d;
            rdata_q      <= rdata_d;
            resp_err_q   <= resp_err_d;
            busy_q       <= busy_d;
            ready_q      <= ready_d;
        end
    end

    // Storage is not reset; the reset gate keeps an aborted store from landing.
    always_ff @(posedge clk) begin
        if (commit && cur_wr && !cur_err && !reset) begin
            mem[idx0] <= cur_wdata[7:0];
            if (cur_size != 2'b00) mem[idx1] <= cur_wdata[15:8];
            if (cur_size == 2'b10) begin
                mem[idx2] <= cur_wdata[23:16];
                mem[idx3] <= cur_wdata[31:24];
            end
        end
    end

    assign req_ready  = ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = resp_err_q;
    assign busy       = busy_q;
endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder with WAIT_CYCLES=3, ADDR_WIDTH=8.
module tb_mem_responder;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        busy;

    int tests_run = 0;
    int fails = 0;
    logic [32:0] sb [$];

    mem_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(3)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // One full transaction: push expectation, accept, wait for the response, pop and compare.
    task automatic send(input logic wr, input logic [1:0] sz, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic exp_err,
                        input logic [31:0] exp_rd, input string name);
        int cyc;
        logic got;
        logic [32:0] exp;
        sb.push_back({exp_err, exp_rd});
        @(negedge clk);
        tests_run++;
        if (req_ready !== 1'b1) begin
            fails++;
            $display("FAIL %s ready_before_accept: got %b want 1", name, req_ready);
        end
        req_write = wr; req_size = sz; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        cyc = 0; got = 1'b0;
        while (cyc < 20 && !got) begin
            @(negedge clk);
            cyc++;
            if (resp_valid === 1'b1) got = 1'b1;
        end
        exp = sb.pop_front();
        tests_run++;
        if (!got) begin
            fails++;
            $display("FAIL %s timeout: no resp_valid within %0d cycles", name, cyc);
        end else begin
            if (cyc != 4) begin
                fails++;
                $display("FAIL %s latency: got %0d want 4", name, cyc);
            end
            tests_run++;
            if (resp_err !== exp[32]) begin
                fails++;
                $display("FAIL %s err: got %b want %b", name, resp_err, exp[32]);
            end
            tests_run++;
            if (resp_rdata !== exp[31:0]) begin
                fails++;
                $display("FAIL %s rdata: got %h want %h", name, resp_rdata, exp[31:0]);
            end
        end
    endtask

    task automatic test_reset();
        #2;
        tests_run++;
        if ({resp_valid, resp_err, busy, resp_rdata} !== 35'd0) begin
            fails++;
            $display("FAIL reset_outputs: got v=%b e=%b b=%b d=%h want all 0",
                     resp_valid, resp_err, busy, resp_rdata);
        end
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        tests_run++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_ready: got ready=%b busy=%b want 1/0", req_ready, busy);
        end
    endtask

    task automatic test_timing();
        logic [2:0] got, want;
        @(negedge clk);
        req_write = 1'b0; req_size = 2'b00; req_addr = 32'h30; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            got  = {req_ready, busy, resp_valid};
            want = {c >= 5, c <= 4, c == 4};
            tests_run++;
            if (got !== want) begin
                fails++;
                $display("FAIL timing_cycle%0d: got rdy/busy/vld=%b want %b", c, got, want);
            end
        end
    endtask

    task automatic test_data();
        send(1'b1, 2'b10, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, "store_word");
        send(1'b0, 2'b00, 32'h11, 32'h0, 1'b0, 32'h000000BE, "load_byte_11");
        send(1'b0, 2'b01, 32'h12, 32'h0, 1'b0, 32'h0000DEAD, "load_half_12");
        send(1'b0, 2'b10, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, "load_word_10");
        send(1'b1, 2'b00, 32'h13, 32'h0000005A, 1'b0, 32'h0, "store_byte_13");
        send(1'b0, 2'b10, 32'h10, 32'h0, 1'b0, 32'h5AADBEEF, "load_word_merge");
    endtask

    task automatic test_errors();
        send(1'b0, 2'b10, 32'h02, 32'h0, 1'b1, 32'h0, "word_misalign");
        send(1'b1, 2'b01, 32'h11, 32'h0000FFFF, 1'b1, 32'h0, "half_misalign_store");
        send(1'b0, 2'b10, 32'h10, 32'h0, 1'b0, 32'h5AADBEEF, "word_unchanged");
        send(1'b0, 2'b11, 32'h10, 32'h0, 1'b1, 32'h0, "size_illegal");
        send(1'b0, 2'b00, 32'h100, 32'h0, 1'b1, 32'h0, "byte_out_of_range");
        send(1'b1, 2'b00, 32'hFF, 32'h00000077, 1'b0, 32'h0, "store_byte_ff");
        send(1'b0, 2'b00, 32'hFF, 32'h0, 1'b0, 32'h00000077, "load_byte_ff");
    endtask

    task automatic test_abort();
        int seen;
        send(1'b1, 2'b10, 32'h20, 32'hCAFEF00D, 1'b0, 32'h0, "prior_store");
        @(negedge clk);
        req_write = 1'b1; req_size = 2'b10; req_addr = 32'h20; req_wdata = 32'h12345678;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (resp_valid === 1'b1) seen++;
        end
        tests_run++;
        if (seen != 0) begin
            fails++;
            $display("FAIL abort_no_resp: got %0d responses want 0", seen);
        end
        tests_run++;
        if (busy !== 1'b0 || req_ready !== 1'b1) begin
            fails++;
            $display("FAIL abort_idle: got busy=%b ready=%b want 0/1", busy, req_ready);
        end
        send(1'b0, 2'b10, 32'h20, 32'h0, 1'b0, 32'hCAFEF00D, "abort_no_store");
    endtask

    initial begin
        test_reset();
        test_timing();
        test_data();
        test_errors();
        test_abort();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end
endmodule
